// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file and interrupt/trap sequencer for the RV32 pipeline.
// Executes CSR/MRET/WFI operations in EX, holds mstatus/mie/mip/mepc/mcause/mtvec and the
// 64-bit cycle/instret counters, takes external/timer interrupts and parks the core in WFI.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   csr_en_i .. csr_zimm_i   CSR instruction fields from EX
//   mret_i, wfi_i, ex_pc_i   system instruction flags and EX PC
//   stall_i, instret_i       pipeline hold and retire strobe
//   ext_irq_i, tmr_irq_i     interrupt levels
//   csr_rdata_o              pre-write CSR value (combinational)
//   redirect_o/_pc_o         PC redirect + flush pulse (combinational)
//   wfi_stall_o              freeze fetch while sleeping (combinational)
module csr_irq_unit #(
  parameter logic [31:0] MTVEC_ADDR = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en_i,
  input  logic [2:0]  csr_funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_rs1_i,
  input  logic [4:0]  csr_zimm_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic [31:0] ex_pc_i,
  input  logic        stall_i,
  input  logic        instret_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        wfi_stall_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, 31'd11};
  localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, 31'd7};
  localparam logic [XLEN-1:0] PC_MASK   = ~XLEN'(3);

  typedef enum logic {RUN = 1'b0, SLEEP = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            mst_mie, mst_mpie;
  logic            mie_mtie, mie_meie;
  logic [XLEN-1:0] mepc, mcause, wfi_pc;
  logic [CW-1:0]   mcycle, minstret;

  logic            pend_ext, pend_tmr, pend_any;
  logic [XLEN-1:0] csr_old, csr_src, csr_wdata;
  logic            csr_wr_ok;
  logic            do_trap, do_mret, csr_we, latch_wfi;
  logic [XLEN-1:0] trap_pc;
  logic            redirect, wfi_stall;
  logic [XLEN-1:0] redirect_pc;

  assign pend_ext = mie_meie & ext_irq_i;
  assign pend_tmr = mie_mtie & tmr_irq_i;
  assign pend_any = pend_ext | pend_tmr;

  // CSR read mux (pre-write value)
  always_comb begin
    csr_old = '0;
    case (csr_addr_i)
      A_MSTATUS:   csr_old = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      A_MIE:       csr_old = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
      A_MTVEC:     csr_old = MTVEC_ADDR;
      A_MEPC:      csr_old = mepc;
      A_MCAUSE:    csr_old = mcause;
      A_MIP:       csr_old = {20'b0, ext_irq_i, 3'b0, tmr_irq_i, 7'b0};
      A_MCYCLE:    csr_old = mcycle[31:0];
      A_MCYCLEH:   csr_old = mcycle[63:32];
      A_MINSTRET:  csr_old = minstret[31:0];
      A_MINSTRETH: csr_old = minstret[63:32];
      default:     csr_old = '0;
    endcase
  end

  // Write value: RW / RS / RC; set/clear with a zero rs1 index or zimm writes nothing
  always_comb begin
    csr_src   = csr_funct3_i[2] ? XLEN'(csr_zimm_i) : csr_rs1_i;
    csr_wdata = csr_old;
    case (csr_funct3_i[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = csr_old | csr_src;
      2'b11:   csr_wdata = csr_old & ~csr_src;
      default: csr_wdata = csr_old;
    endcase
    csr_wr_ok = (csr_funct3_i[1:0] != 2'b00) && !(csr_funct3_i[1] && (csr_zimm_i == 5'd0));
  end

  // Next-state and decision logic; interrupts beat any EX operation
  always_comb begin
    state_nxt   = state;
    do_trap     = 1'b0;
    do_mret     = 1'b0;
    csr_we      = 1'b0;
    latch_wfi   = 1'b0;
    trap_pc     = ex_pc_i;
    wfi_stall   = 1'b0;
    case (state)
      RUN: begin
        if (!stall_i) begin
          if (mst_mie && pend_any) begin
            do_trap = 1'b1;
          end else if (mret_i) begin
            do_mret = 1'b1;
          end else if (wfi_i) begin
            state_nxt = SLEEP;
            latch_wfi = 1'b1;
          end else if (csr_en_i && csr_wr_ok) begin
            csr_we = 1'b1;
          end
        end
      end
      SLEEP: begin
        // Wake on any enabled pending source; trap only if globally enabled
        wfi_stall = !pend_any;
        if (pend_any) begin
          state_nxt = RUN;
          if (mst_mie) begin
            do_trap = 1'b1;
            trap_pc = wfi_pc + XLEN'(4);
          end
        end
      end
      default: state_nxt = RUN;
    endcase
    redirect    = do_trap | do_mret;
    redirect_pc = do_trap ? MTVEC_ADDR : (do_mret ? mepc : '0);
  end

  assign csr_rdata_o   = rst ? csr_old     : '0;
  assign redirect_o    = rst ? redirect    : 1'b0;
  assign redirect_pc_o = rst ? redirect_pc : '0;
  assign wfi_stall_o   = rst ? wfi_stall   : 1'b0;

  // State and CSR registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mepc     <= '0;
      mcause   <= '0;
      wfi_pc   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      state <= state_nxt;
      if (latch_wfi) wfi_pc <= ex_pc_i;

      if (do_trap) begin
        mepc     <= trap_pc & PC_MASK;
        mcause   <= pend_ext ? CAUSE_EXT : CAUSE_TMR;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (do_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mst_mie  <= csr_wdata[3];
            mst_mpie <= csr_wdata[7];
          end
          A_MIE: begin
            mie_mtie <= csr_wdata[7];
            mie_meie <= csr_wdata[11];
          end
          A_MEPC:   mepc   <= csr_wdata & PC_MASK;
          A_MCAUSE: mcause <= csr_wdata;
          default: ;
        endcase
      end

      // A committed write to a counter half replaces it and drops that cycle's increment
      if (csr_we && csr_addr_i == A_MCYCLE)       mcycle[31:0]  <= csr_wdata;
      else if (csr_we && csr_addr_i == A_MCYCLEH) mcycle[63:32] <= csr_wdata;
      else                                        mcycle        <= mcycle + CW'(1);

      if (csr_we && csr_addr_i == A_MINSTRET)       minstret[31:0]  <= csr_wdata;
      else if (csr_we && csr_addr_i == A_MINSTRETH) minstret[63:32] <= csr_wdata;
      else                                          minstret        <= minstret + CW'(instret_i);
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: self-checking bench for csr_irq_unit. A cycle-level reference model
// derived from the CSR/trap rules predicts every output each cycle; a vector table and
// directed sequences add fixed expected values for the interesting cases.
module tb_csr_irq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [2:0]  f3;
  logic [11:0] addr;
  logic [31:0] rs1;
  logic [4:0]  zimm;
  logic        mret, wfi, stall, instret, ext, tmr;
  logic [31:0] ex_pc;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        wfi_stall;

  csr_irq_unit dut (
    .clk(clk), .rst(rst), .csr_en_i(csr_en), .csr_funct3_i(f3), .csr_addr_i(addr),
    .csr_rs1_i(rs1), .csr_zimm_i(zimm), .mret_i(mret), .wfi_i(wfi), .ex_pc_i(ex_pc),
    .stall_i(stall), .instret_i(instret), .ext_irq_i(ext), .tmr_irq_i(tmr),
    .csr_rdata_o(csr_rdata), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .wfi_stall_o(wfi_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state (current and next)
  logic        m_mie, m_mpie, m_mtie, m_meie, m_sleep;
  logic [31:0] m_mepc, m_mcause, m_wfipc;
  logic [63:0] m_cyc, m_ins;
  logic        n_mie, n_mpie, n_mtie, n_meie, n_sleep;
  logic [31:0] n_mepc, n_mcause, n_wfipc;
  logic [63:0] n_cyc, n_ins;
  logic [31:0] e_rdata, e_rpc;
  logic        e_redir, e_stall;
  logic [31:0] s_rdata, s_rpc;
  logic        s_redir, s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h304: return (m_mtie ? 32'h80 : 32'h0) + (m_meie ? 32'h800 : 32'h0);
      12'h305: return 32'h0001_0000;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (tmr ? 32'h80 : 32'h0) + (ext ? 32'h800 : 32'h0);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin n_mie = v[3]; n_mpie = v[7]; end
      12'h304: begin n_mtie = v[7]; n_meie = v[11]; end
      12'h341: n_mepc = v & 32'hFFFF_FFFC;
      12'h342: n_mcause = v;
      12'hB00: n_cyc = {m_cyc[63:32], v};
      12'hB80: n_cyc = {v, m_cyc[31:0]};
      12'hB02: n_ins = {m_ins[63:32], v};
      12'hB82: n_ins = {v, m_ins[31:0]};
      default: ;
    endcase
  endtask

  task automatic model_eval();
    logic pe, pt, pa, trap;
    logic [31:0] old, src, nv, tpc;
    n_mie = m_mie; n_mpie = m_mpie; n_mtie = m_mtie; n_meie = m_meie; n_sleep = m_sleep;
    n_mepc = m_mepc; n_mcause = m_mcause; n_wfipc = m_wfipc;
    e_rdata = 0; e_redir = 0; e_rpc = 0; e_stall = 0;
    if (!rst) begin
      n_mie = 0; n_mpie = 0; n_mtie = 0; n_meie = 0; n_sleep = 0;
      n_mepc = 0; n_mcause = 0; n_cyc = 0; n_ins = 0;
      return;
    end
    pe = m_meie && ext;
    pt = m_mtie && tmr;
    pa = pe || pt;
    old = model_read(addr);
    e_rdata = old;
    n_cyc = m_cyc + 64'd1;
    n_ins = m_ins + (instret ? 64'd1 : 64'd0);
    trap = 0;
    tpc = 0;
    if (m_sleep) begin
      e_stall = !pa;
      if (pa) begin
        n_sleep = 0;
        if (m_mie) begin trap = 1; tpc = m_wfipc + 32'd4; end
      end
    end else if (!stall) begin
      if (m_mie && pa) begin
        trap = 1; tpc = ex_pc;
      end else if (mret) begin
        e_redir = 1; e_rpc = m_mepc; n_mie = m_mpie; n_mpie = 1;
      end else if (wfi) begin
        n_sleep = 1; n_wfipc = ex_pc;
      end else if (csr_en) begin
        src = f3[2] ? {27'd0, zimm} : rs1;
        nv = old;
        if (f3[1:0] == 2'd1) nv = src;
        if (f3[1:0] == 2'd2) nv = old | src;
        if (f3[1:0] == 2'd3) nv = old & ~src;
        if (f3[1:0] != 2'd0 && !(f3[1] && zimm == 5'd0)) model_write(addr, nv);
      end
    end
    if (trap) begin
      e_redir = 1; e_rpc = 32'h0001_0000;
      n_mepc = tpc & 32'hFFFF_FFFC;
      n_mpie = m_mie; n_mie = 0;
      n_mcause = pe ? 32'h8000_000B : 32'h8000_0007;
    end
  endtask

  task automatic model_commit();
    m_mie = n_mie; m_mpie = n_mpie; m_mtie = n_mtie; m_meie = n_meie; m_sleep = n_sleep;
    m_mepc = n_mepc; m_mcause = n_mcause; m_wfipc = n_wfipc; m_cyc = n_cyc; m_ins = n_ins;
  endtask

  // One clock cycle: predict, sample mid-cycle, compare, advance the model
  task automatic cyc();
    model_eval();
    @(negedge clk);
    s_rdata = csr_rdata; s_redir = redirect; s_rpc = redirect_pc; s_stall = wfi_stall;
    chk("rdata", s_rdata, e_rdata);
    chk("redirect", {31'd0, s_redir}, {31'd0, e_redir});
    chk("redirect_pc", s_rpc, e_rpc);
    chk("wfi_stall", {31'd0, s_stall}, {31'd0, e_stall});
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input logic [11:0] a);
    rst = 1; csr_en = 0; f3 = 0; addr = a; rs1 = 0; zimm = 0;
    mret = 0; wfi = 0; stall = 0; instret = 0; ex_pc = 32'h0000_0100;
  endtask

  task automatic op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] r,
                    input logic [4:0] z);
    csr_en = 1; f3 = f; addr = a; rs1 = r; zimm = z;
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [2:0] f, input logic [11:0] a,
                              input logic [31:0] r, input logic [4:0] z, input logic [31:0] x);
    vec_t v;
    v.en = e; v.f3 = f; v.addr = a; v.rs1 = r; v.zimm = z; v.exp_rdata = x;
    return v;
  endfunction

  localparam logic [11:0] ADDRS [16] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h340, 12'h300, 12'h304, 12'h342, 12'h341};

  initial begin
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_sleep = 0;
    m_mepc = 0; m_mcause = 0; m_wfipc = 0; m_cyc = 0; m_ins = 0;
    ext = 0; tmr = 0;
    idle(12'h300);
    rst = 0;
    cyc();
    chk("reset_rdata", s_rdata, 32'h0);
    chk("reset_stall", {31'd0, s_stall}, 32'd0);
    cyc();
    rst = 1;

    // CSR operation vectors
    vecs.push_back(mk(1, 3'b001, 12'h304, 32'h880, 5'd5, 32'h0));
    vecs.push_back(mk(0, 3'b000, 12'h304, 32'h0, 5'd0, 32'h880));
    vecs.push_back(mk(1, 3'b001, 12'h342, 32'h880, 5'd3, 32'h0));
    vecs.push_back(mk(1, 3'b010, 12'h342, 32'h8, 5'd4, 32'h880));
    vecs.push_back(mk(0, 3'b000, 12'h342, 32'h0, 5'd0, 32'h888));
    vecs.push_back(mk(1, 3'b111, 12'h342, 32'h0, 5'd8, 32'h888));
    vecs.push_back(mk(0, 3'b000, 12'h342, 32'h0, 5'd0, 32'h880));
    vecs.push_back(mk(1, 3'b010, 12'h342, 32'hFFFF, 5'd0, 32'h880));
    vecs.push_back(mk(0, 3'b000, 12'h342, 32'h0, 5'd0, 32'h880));
    vecs.push_back(mk(0, 3'b000, 12'h123, 32'h0, 5'd0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 12'h123, 32'hDEAD, 5'd1, 32'h0));
    vecs.push_back(mk(0, 3'b000, 12'h123, 32'h0, 5'd0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 12'h305, 32'h0, 5'd1, 32'h0001_0000));
    vecs.push_back(mk(0, 3'b000, 12'h305, 32'h0, 5'd0, 32'h0001_0000));
    vecs.push_back(mk(1, 3'b001, 12'h300, 32'hFFFF_FFFF, 5'd1, 32'h1800));
    vecs.push_back(mk(1, 3'b001, 12'h300, 32'h0, 5'd1, 32'h1888));
    vecs.push_back(mk(0, 3'b000, 12'h300, 32'h0, 5'd0, 32'h1800));
    vecs.push_back(mk(1, 3'b001, 12'h341, 32'h1237, 5'd2, 32'h0));
    vecs.push_back(mk(0, 3'b000, 12'h341, 32'h0, 5'd0, 32'h1234));
    vecs.push_back(mk(0, 3'b000, 12'h344, 32'h0, 5'd0, 32'h0));
    foreach (vecs[i]) begin
      idle(vecs[i].addr);
      if (vecs[i].en) op(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].zimm);
      cyc();
      chk($sformatf("vec%0d", i), s_rdata, vecs[i].exp_rdata);
    end

    // External interrupt beats a CSR write; MRET returns
    idle(12'h300); op(3'b110, 12'h300, 32'h0, 5'd8); cyc();
    idle(12'h341); op(3'b001, 12'h341, 32'h55, 5'd1); ext = 1; ex_pc = 32'h200; cyc();
    chk("irq_redirect", {31'd0, s_redir}, 32'd1);
    chk("irq_pc", s_rpc, 32'h0001_0000);
    idle(12'h341); cyc(); chk("irq_mepc", s_rdata, 32'h200);
    chk("irq_masked", {31'd0, s_redir}, 32'd0);
    idle(12'h342); cyc(); chk("irq_mcause", s_rdata, 32'h8000_000B);
    idle(12'h300); cyc(); chk("irq_mstatus", s_rdata, 32'h1880);
    ext = 0; idle(12'h300); mret = 1; cyc();
    chk("mret_pc", s_rpc, 32'h200);
    idle(12'h300); cyc(); chk("mret_mstatus", s_rdata, 32'h1888);

    // Both sources pending, held by stall first
    idle(12'h342); ext = 1; tmr = 1; stall = 1; ex_pc = 32'h240; cyc();
    chk("stall_no_redir0", {31'd0, s_redir}, 32'd0);
    cyc();
    chk("stall_no_redir1", {31'd0, s_redir}, 32'd0);
    stall = 0; ex_pc = 32'h240; cyc();
    chk("both_redirect", {31'd0, s_redir}, 32'd1);
    ext = 0; tmr = 0; idle(12'h342); cyc(); chk("both_mcause", s_rdata, 32'h8000_000B);
    idle(12'h300); mret = 1; cyc(); chk("both_mret_pc", s_rpc, 32'h240);

    // WFI with MIE=0: wake without redirect
    idle(12'h300); op(3'b111, 12'h300, 32'h0, 5'd8); cyc();
    idle(12'h300); wfi = 1; ex_pc = 32'h300; cyc();
    chk("wfi_commit_stall", {31'd0, s_stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(12'h300); ex_pc = 32'h9990; cyc();
      chk("wfi_sleeping", {31'd0, s_stall}, 32'd1);
    end
    tmr = 1; cyc();
    chk("wfi_wake_stall", {31'd0, s_stall}, 32'd0);
    chk("wfi_wake_noredir", {31'd0, s_redir}, 32'd0);
    cyc();
    chk("wfi_run_noredir", {31'd0, s_redir}, 32'd0);
    tmr = 0;

    // WFI with MIE=1: trap on wake with mepc = wfi_pc + 4
    idle(12'h300); op(3'b110, 12'h300, 32'h0, 5'd8); cyc();
    idle(12'h300); wfi = 1; ex_pc = 32'h400; cyc();
    for (int i = 0; i < 3; i++) begin
      idle(12'h300); cyc();
      chk("wfi2_sleeping", {31'd0, s_stall}, 32'd1);
    end
    tmr = 1; cyc();
    chk("wfi2_wake_stall", {31'd0, s_stall}, 32'd0);
    chk("wfi2_redirect", {31'd0, s_redir}, 32'd1);
    chk("wfi2_pc", s_rpc, 32'h0001_0000);
    tmr = 0; idle(12'h341); cyc(); chk("wfi2_mepc", s_rdata, 32'h404);
    idle(12'h342); cyc(); chk("wfi2_mcause", s_rdata, 32'h8000_0007);
    idle(12'h300); mret = 1; cyc(); chk("wfi2_mret_pc", s_rpc, 32'h404);
    idle(12'h300); op(3'b111, 12'h300, 32'h0, 5'd8); cyc();

    // Counter carry and write-over-increment
    idle(12'hB80); op(3'b001, 12'hB80, 32'h0, 5'd1); cyc();
    idle(12'hB00); op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1); cyc();
    idle(12'hB00); cyc(); chk("mcycle_pre", s_rdata, 32'hFFFF_FFFF);
    idle(12'hB80); cyc(); chk("mcycleh_carry", s_rdata, 32'h1);
    idle(12'hB02); op(3'b001, 12'hB02, 32'h1234, 5'd1); instret = 1; cyc();
    idle(12'hB02); cyc(); chk("minstret_write", s_rdata, 32'h1234);
    idle(12'hB02); instret = 1; cyc(); chk("minstret_hold", s_rdata, 32'h1234);
    idle(12'hB02); cyc(); chk("minstret_inc", s_rdata, 32'h1235);

    // Reset while sleeping
    idle(12'h300); wfi = 1; ex_pc = 32'h500; cyc();
    idle(12'h300); cyc(); chk("rs_sleeping", {31'd0, s_stall}, 32'd1);
    idle(12'h341); rst = 0; cyc();
    chk("rs_in_reset_stall", {31'd0, s_stall}, 32'd0);
    chk("rs_in_reset_rdata", s_rdata, 32'h0);
    idle(12'hB00); cyc();
    chk("rs_after_stall", {31'd0, s_stall}, 32'd0);
    chk("rs_mcycle0", s_rdata, 32'h0);
    idle(12'hB00); cyc(); chk("rs_mcycle1", s_rdata, 32'h1);
    idle(12'h300); cyc(); chk("rs_mstatus", s_rdata, 32'h1800);
    idle(12'h304); cyc(); chk("rs_mie", s_rdata, 32'h0);
    idle(12'h341); cyc(); chk("rs_mepc", s_rdata, 32'h0);
    idle(12'h342); cyc(); chk("rs_mcause", s_rdata, 32'h0);
    idle(12'hB02); cyc(); chk("rs_minstret", s_rdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) != 0);
      csr_en  = 1'($urandom_range(0, 1));
      f3      = 3'($urandom_range(0, 7));
      addr    = ADDRS[$urandom_range(0, 15)];
      rs1     = $urandom;
      zimm    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      mret    = ($urandom_range(0, 19) == 0);
      wfi     = ($urandom_range(0, 29) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      instret = 1'($urandom_range(0, 1));
      ext     = ($urandom_range(0, 9) == 0);
      tmr     = ($urandom_range(0, 9) == 0);
      ex_pc   = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
